// File: rtl/sseg_scan.sv
// Multiplexed 7-segment scanner with blank-window anti-ghosting and a tear-free shadow/display register pair.
// Define SSEG_LZB_EN to enable leading-zero blanking.
module sseg_scan #(
   parameter int N_DIGITS     = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   digits_i,
   input  logic [N_DIGITS-1:0]     dp_i,
   input  logic [N_DIGITS-1:0]     en_i,
   input  logic                    load_i,
   output logic [N_DIGITS-1:0]     an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_o
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] s;
      case (hex)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*N_DIGITS-1:0]   sh_dig_q, sh_dig_d, disp_dig_q, disp_dig_d;
   logic [N_DIGITS-1:0]     sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
   logic [N_DIGITS-1:0]     sh_en_q, sh_en_d, disp_en_q, disp_en_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic                    frame_q, frame_d;

   logic                    slot_end_s, frame_end_s;
   logic [N_DIGITS-1:0]     lz_s;
   logic [3:0]              cur_dig_s;
   logic                    cur_dp_s, cur_en_s, lit_s;

   assign an      = an_q;
   assign seg     = seg_q;
   assign dp      = dp_q;
   assign frame_o = frame_q;

   // Prescaler and digit index advance
   always_comb begin
      slot_end_s  = (presc_q == PRESC_LAST);
      frame_end_s = slot_end_s && (idx_q == IDX_LAST);
      if (slot_end_s) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end
      if (frame_end_s) begin
         idx_d = '0;
      end else if (slot_end_s) begin
         idx_d = idx_q + IW'(1);
      end else begin
         idx_d = idx_q;
      end
   end

   // Shadow capture; display takes the shadow's next value at the frame boundary,
   // so a load on the boundary cycle passes straight through
   always_comb begin
      if (load_i) begin
         sh_dig_d = digits_i;
         sh_dp_d  = dp_i;
         sh_en_d  = en_i;
      end else begin
         sh_dig_d = sh_dig_q;
         sh_dp_d  = sh_dp_q;
         sh_en_d  = sh_en_q;
      end
      if (frame_end_s) begin
         disp_dig_d = sh_dig_d;
         disp_dp_d  = sh_dp_d;
         disp_en_d  = sh_en_d;
      end else begin
         disp_dig_d = disp_dig_q;
         disp_dp_d  = disp_dp_q;
         disp_en_d  = disp_en_q;
      end
   end

`ifdef SSEG_LZB_EN
   logic lz_run_s;

   // A digit is a leading zero when it and every higher digit are 0 with no decimal point
   always_comb begin
      lz_run_s = 1'b1;
      lz_s     = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         lz_run_s = lz_run_s & (disp_dig_q[4*k +: 4] == 4'h0) & ~disp_dp_q[k];
         lz_s[k]  = lz_run_s;
      end
   end
`else
   assign lz_s = '0;
`endif

   // Pin values for the current slot, registered one clock later
   always_comb begin
      cur_dig_s = disp_dig_q[{idx_q, 2'b00} +: 4];
      cur_dp_s  = disp_dp_q[idx_q];
      cur_en_s  = disp_en_q[idx_q] & ~lz_s[idx_q];
      lit_s     = (presc_q >= BLANK_END) && cur_en_s;
      for (int k = 0; k < N_DIGITS; k++) begin
         an_d[k] = ~(lit_s && (idx_q == IW'(k)));
      end
      if (lit_s) begin
         seg_d = hex_to_seg(cur_dig_s);
         dp_d  = ~cur_dp_s;
      end else begin
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end
      frame_d = frame_end_s;
   end

   // Scan and data state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= '0;
         sh_dig_q   <= '0;
         sh_dp_q    <= '0;
         sh_en_q    <= '0;
         disp_dig_q <= '0;
         disp_dp_q  <= '0;
         disp_en_q  <= '0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_en_q    <= sh_en_d;
         disp_dig_q <= disp_dig_d;
         disp_dp_q  <= disp_dp_d;
         disp_en_q  <= disp_en_d;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q    <= '1;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: doc/sseg_scan.md
SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 Parameter N_DIGITS, 4, number of multiplexed 7-segment digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, 100000, clk cycles per digit slot; legal minimum 2*BLANK_CYCLES+1.
REQ-003 Parameter BLANK_CYCLES, 4, anti-ghosting cycles at the start of each slot, with all anodes off.
REQ-004 Port clk, input, 1, single system clock; all state is clocked on the rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 Port digits_i, input, 4*N_DIGITS, hex nibbles; digit k = digits_i[4k+3:4k], and digit 0 is rightmost.
REQ-007 Port dp_i, input, N_DIGITS, decimal point request per digit; 1 = lit.
REQ-008 Port en_i, input, N_DIGITS, digit enable; 0 = digit dark for its slot.
REQ-009 Port load_i, input, 1, single-cycle strobe that captures digits_i, dp_i and en_i into the shadow register.
REQ-010 Port an, output, N_DIGITS, anode select; active-low, one-hot-low or all-high.
REQ-011 Port seg, output, 7, cathodes {g,f,e,d,c,b,a}; active-low.
REQ-012 Port dp, output, 1, decimal point cathode; active-low.
REQ-013 Port frame_o, output, 1, one-cycle pulse marking completion of a full scan of all digits.

Function
REQ-014 The prescaler shall count 0..REFRESH_DIV-1 and then wrap to 0.
REQ-015 The digit index shall advance by one on each prescaler wrap, wrapping from N_DIGITS-1 to 0.
REQ-016 When the index wraps from N_DIGITS-1 to 0, frame_o shall pulse high for exactly one cycle.
REQ-017 load_i shall capture the inputs into the shadow register on the cycle it is sampled high.
REQ-018 The display register shall copy the shadow register only at a frame boundary, so no frame shows mixed data (tear-free).
REQ-019 If load_i coincides with the frame-boundary cycle, the inputs of that cycle shall go directly to the display register.
REQ-020 While prescaler < BLANK_CYCLES, an shall be all-high and seg/dp shall be all-high.
REQ-021 Otherwise, an[index] shall be 0 if en[index]=1, and all anodes shall be high if en[index]=0.
REQ-022 Hex decode (active-low, gfedcba) shall be: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-023 an, seg, dp and frame_o shall be registered, with one clk of latency from prescaler/index state to pins.
REQ-024 Only one anode shall ever be low in any cycle.

Reset
REQ-025 On rst_n low, the prescaler, index, shadow register and display register shall clear to 0.
REQ-026 On rst_n low, an, seg and dp shall be all-high and frame_o shall be 0.
REQ-027 Reset asserted mid-slot or mid-frame shall abort immediately; after release, scanning shall restart at digit 0 with a blank window.
REQ-028 After rst_n release, the display shall stay dark until the first load_i and the subsequent frame boundary.

Configuration
REQ-029 Macro SSEG_LZB_EN shall enable leading-zero blanking.
REQ-030 With SSEG_LZB_EN defined, digit k>0 shall be treated as en=0 when it and all higher digits are 0 and their dp bits are 0; digit 0 is never blanked.
REQ-031 Without SSEG_LZB_EN, all enabled digits shall display as decoded, including leading zeros.

Verification (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-032 Reset scenario: hold rst_n=0 mid-scan -> an=4'hF, seg=7'h7F, dp=1, frame_o=0 immediately; after release, the first active slot is digit 0.
REQ-033 Scan scenario: load_i with digits_i=16'h1234, en_i=4'hF.
- After the next frame, an cycles E,D,B,7, each low for 6 of 8 cycles.
- seg shows 7'h19, 7'h30, 7'h24, 7'h79 in that order.
- frame_o pulses every 32 cycles.
REQ-034 Tear-free scenario: load 16'hABCD mid-frame -> digits already shown in that frame keep their old values until frame_o; the new values appear from the next digit-0 slot.
REQ-035 Coincidence scenario: load_i on the frame-boundary cycle with 16'h00F0 -> the new data is displayed in the immediately following frame.
REQ-036 Blanking and dp scenario: en_i=4'b0101, dp_i=4'b0001 -> an stays all-high in slots 1 and 3, and dp=0 only during the digit-0 active window.
REQ-037 Leading-zero scenario, with SSEG_LZB_EN: 16'h0070 -> digits 3 and 2 dark, digits 1 and 0 show 7'h78 and 7'h40. Without the macro, all four digits are lit.
